mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (legal range 1..31).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (legal range 1..31).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  E-stage instruction is an MDU operation; valid for one cycle.
REQ-006 op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6..7 reserved.
REQ-007 rs_data  input  32  forwarded rs operand from E stage.
REQ-008 rt_data  input  32  forwarded rt operand from E stage.
REQ-009 md_use_d  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse in the cycle HI/LO first show a new multiply/divide result.
REQ-012 stall  output  1  stall request to hazard unit (freeze PC and D, clear E).
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 States IDLE and BUSY; 5-bit down-counter cnt; latched op and operand registers.
REQ-016 IDLE + start + op 0..3 at edge T: latch op/operands, cnt <= N-1 (N = MULT_CYCLES or DIV_CYCLES), go BUSY; busy = 1 in cycles T+1..T+N.
REQ-017 BUSY: cnt decrements each edge; at edge with cnt == 0 write HI/LO, go IDLE, done = 1 for the following cycle, busy = 0.
REQ-018 hi/lo hold previous values throughout BUSY; no partial results visible.
REQ-019 mult: {hi,lo} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-020 div: lo = signed quotient truncated toward zero, hi = remainder with dividend's sign; divu: unsigned quotient/remainder; dividend rs_data, divisor rt_data.
REQ-021 Divisor zero: full DIV_CYCLES busy period, done pulses, hi/lo unchanged.
REQ-022 mthi/mtlo in IDLE: hi (or lo) <= rs_data at that edge, busy and done stay 0.
REQ-023 start while BUSY (any op): ignored, no state change.
REQ-024 Reserved op with start: ignored.
REQ-025 stall = md_use_d & (busy | (start & op <= 3)); combinational.
REQ-026 Operand capture occurs only at the accepting edge; later rs_data/rt_data changes do not affect the result.

Reset
REQ-027 reset asserted: immediately state IDLE, cnt 0, busy 0, done 0, hi 0, lo 0, independent of clk.
REQ-028 reset during BUSY aborts the operation; no HI/LO write and no done pulse afterwards.
REQ-029 stall is 0 while reset is asserted.

Configuration
REQ-030 Macro MDU_DIV_EN defined: divider logic compiled in; div/divu behave per REQ-016..REQ-021.
REQ-031 MDU_DIV_EN undefined: no divider hardware; op 2/3 treated as reserved (REQ-024), never assert busy or stall, hi/lo unchanged.

Verification
REQ-032 mult rs=0xFFFFFFFE (-2), rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle.
REQ-033 divu rs=100, rt=7 -> busy 10 cycles, then lo=14, hi=2; div rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 mthi rs=0x12345678 -> hi=0x12345678 next cycle, busy never high; div rt=0 -> 10 busy cycles, hi/lo unchanged.
REQ-035 mult accepted, md_use_d=1 during cycles 1..5 -> stall=1 exactly those cycles plus the start cycle, 0 after; second start mid-busy leaves result of first.
REQ-036 reset pulse in busy cycle 3 of multu -> busy/hi/lo/done 0 immediately, no done pulse afterwards.
REQ-037 Build without MDU_DIV_EN: div rs=100, rt=7 -> busy 0, stall 0, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
//
// Multiply/divide unit controller for a MIPS-style pipeline. Owns the HI/LO
// architectural registers and models the latency of a multi-cycle multiplier
// and divider. An E-stage MDU instruction is accepted only while idle. Its
// operands are captured at the accepting edge. The result is written to HI/LO
// in a single step at the end of the busy period, so no partial result is
// ever visible.
//
// Build option:
//   MDU_DIV_EN  - when defined, the divider is compiled in and div/divu run
//                 for DIV_CYCLES. When undefined, op 2/3 are treated as
//                 reserved and are ignored.
//
// Parameters:
//   MULT_CYCLES - busy cycles for mult/multu (1..31)
//   DIV_CYCLES  - busy cycles for div/divu   (1..31)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   E-stage instruction is an MDU op (one-cycle valid)
//   op       in   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6..7 rsvd
//   rs_data  in   forwarded rs operand (dividend / mthi/mtlo source)
//   rt_data  in   forwarded rt operand (divisor)
//   md_use_d in   D-stage instruction touches the MDU or HI/LO
//   busy     out  multiply/divide in progress
//   done     out  one-cycle pulse when HI/LO first show a new result
//   stall    out  stall request to the hazard unit
//   hi       out  HI register
//   lo       out  LO register
//
// FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no operation running; accepts mult/div and mthi/mtlo
//   BUSY    | counting down the latency; HI/LO written when cnt hits 0
// ---------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_use_d,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // The counter is loaded with N-1 so that it reaches 0 on the Nth edge
    // after acceptance, which gives exactly N busy cycles.
    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;      // bit1: divide, bit0: unsigned
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic [31:0] hi_d;
    logic [31:0] lo_d;

    // -----------------------------------------------------------------------
    // Incoming op decode
    // -----------------------------------------------------------------------
    logic       is_mul;
    logic       is_div;
    logic       launch_op;
    logic [4:0] load_val;

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
`else
    assign is_div = 1'b0;
`endif
    assign launch_op = is_mul || is_div;

    // op[1] can only be set on a launch when the divider is present.
    assign load_val = op[1] ? DIV_LOAD : MULT_LOAD;

    // -----------------------------------------------------------------------
    // Multiplier: a single 64x64 product over sign- or zero-extended operands.
    // The low 64 bits are exact for both the signed and unsigned forms.
    // -----------------------------------------------------------------------
    logic        mul_sgn;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;

    assign mul_sgn  = ~op_q[0];
    assign mul_a    = {{32{mul_sgn & rs_q[31]}}, rs_q};
    assign mul_b    = {{32{mul_sgn & rt_q[31]}}, rt_q};
    assign mul_prod = mul_a * mul_b;

    // -----------------------------------------------------------------------
    // Divider
    // -----------------------------------------------------------------------
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_zero;

`ifdef MDU_DIV_EN
    // The divide works on magnitudes and then restores the signs. This keeps
    // 0x80000000 / -1 well defined: the result wraps to 0x80000000 with
    // remainder 0. It also avoids the tool-dependent behaviour of signed '/'.
    logic        div_sgn;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_b_safe;
    logic [31:0] uquo;
    logic [31:0] urem;

    assign div_sgn    = ~op_q[0];
    assign neg_a      = div_sgn & rs_q[31];
    assign neg_b      = div_sgn & rt_q[31];
    assign mag_a      = neg_a ? (32'd0 - rs_q) : rs_q;
    assign mag_b      = neg_b ? (32'd0 - rt_q) : rt_q;
    assign div_zero   = (rt_q == 32'd0);
    // The result is discarded on a zero divisor. Dividing by 1 instead keeps
    // the datapath free of X.
    assign mag_b_safe = div_zero ? 32'd1 : mag_b;
    assign uquo       = mag_a / mag_b_safe;
    assign urem       = mag_a % mag_b_safe;
    assign div_quo    = (neg_a ^ neg_b) ? (32'd0 - uquo) : uquo;
    assign div_rem    = neg_a ? (32'd0 - urem) : urem;
`else
    // No divider. This path is never selected because op_q[1] is never set.
    assign div_zero = 1'b0;
    assign div_quo  = lo_q;
    assign div_rem  = hi_q;
`endif

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    assign res_hi = op_q[1] ? div_rem : mul_prod[63:32];
    assign res_lo = op_q[1] ? div_quo : mul_prod[31:0];
    assign res_we = ~(op_q[1] & div_zero);

    // -----------------------------------------------------------------------
    // HI/LO next state
    // -----------------------------------------------------------------------
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == ST_BUSY) begin
            if ((cnt_q == 5'd0) && res_we) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end
        end else if (start) begin
            if (op == OP_MTHI) begin
                hi_d = rs_data;
            end else if (op == OP_MTLO) begin
                lo_d = rs_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM and registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && launch_op) begin
                        op_q    <= op[1:0];
                        rs_q    <= rs_data;
                        rt_q    <= rt_data;
                        cnt_q   <= load_val;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A start that arrives here is ignored on purpose.
                    if (cnt_q == 5'd0) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // The start term lets the D-stage MDU instruction wait behind an op that
    // is being accepted this cycle. It is forced low during reset.
    assign stall = ~reset & md_use_d & (busy | (start & launch_op));

endmodule
